// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback/commit stage.
//   - result-source encodings for mem_to_reg
//   - load funct3 codes and the legality/alignment helper
//   - commit FSM state encoding
//   - rd/funct3 bit-field positions within the instruction word
package wb_pkg;

    localparam logic [1:0] WB_SRC_ALU  = 2'd0;
    localparam logic [1:0] WB_SRC_LOAD = 2'd1;
    localparam logic [1:0] WB_SRC_PC4  = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int RD_LSB = 7;
    localparam int RD_MSB = 11;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

    // A load is accepted only for a known funct3 at a naturally aligned address.
    function automatic logic load_ok(input logic [2:0] funct3, input logic [1:0] addr);
        logic ok;
        case (funct3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~addr[0];
            F3_LW:         ok = (addr == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract: picks the byte/halfword lane out of an aligned memory word and
// sign- or zero-extends it according to the load funct3.
//   funct3 in  3     load type (LB/LH/LW/LBU/LHU)
//   addr   in  2     low byte-address bits; selects the lane
//   rdata  in  XLEN  aligned word returned by data memory
//   data   out XLEN  value to be written to the register file
module load_extract
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte lane select by addr[1:0].
    always_comb begin
        byte_s = rdata[7:0];
        case (addr)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
    end

    // Halfword lane select by addr[1]; addr[0] is known to be 0 here.
    always_comb begin
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Sign/zero extension by load type.
    always_comb begin
        data = {XLEN{1'b0}};
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LH:   data = {{(XLEN-16){half_s[15]}}, half_s};
            F3_LW:   data = rdata;
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_s};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_s};
            default: data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writeback/commit stage driving the register-file write port.
// Selects ALU / load / PC+4 as the result, waits for variable-latency load
// responses (holding the front end with stall), and abandons a load after
// MEM_TIMEOUT wait cycles without a response.
//   clk, rst            clock, asynchronous active-high reset
//   instruction         rd=[11:7], funct3=[14:12]
//   reg_write           decode write enable
//   mem_to_reg          0=ALU, 1=LOAD, 2=PC4, 3=ALU
//   alu_result          ALU result / load byte address
//   pc_plus4            link value for JAL/JALR
//   mem_rvalid, mem_rdata   data memory read response
//   stall               combinational front-end hold
//   rf_we/rf_waddr/rf_wdata registered register-file write port
//   load_fault          pulse: illegal funct3 or misaligned load
//   mem_timeout         pulse: load abandoned
module wb_commit_unit
    import wb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction,
    input  logic            reg_write,
    input  logic [1:0]      mem_to_reg,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            load_fault,
    output logic            mem_timeout
);

    localparam int              CW        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]   TIMEOUT_C = CW'(MEM_TIMEOUT);

    wb_state_e       state_r;
    logic [CW-1:0]   cnt_r;
    logic [4:0]      ld_rd_r;
    logic [2:0]      ld_f3_r;
    logic [1:0]      ld_addr_r;

    logic [4:0]      rd_s;
    logic [2:0]      funct3_s;
    logic            is_load_s;
    logic            load_ok_s;
    logic            accept_s;
    logic [XLEN-1:0] sel_data_s;
    logic [XLEN-1:0] ext_data_s;
    logic            unused_bits_s;

    assign rd_s      = instruction[RD_MSB:RD_LSB];
    assign funct3_s  = instruction[F3_MSB:F3_LSB];
    assign is_load_s = (mem_to_reg == WB_SRC_LOAD);
    assign load_ok_s = load_ok(funct3_s, alu_result[1:0]);
    assign accept_s  = (state_r == ST_IDLE) && reg_write && is_load_s && load_ok_s;

    // Opcode and upper instruction bits are decoded upstream.
    assign unused_bits_s = ^{instruction[31:15], instruction[6:0]};

    // Hold fetch while a load is being accepted or still waiting; the cycle the
    // counter hits the limit releases the front end. Reset releases it at once.
    assign stall = ~rst & (accept_s |
                   ((state_r == ST_WAIT_MEM) & ~mem_rvalid & (cnt_r != TIMEOUT_C)));

    // Non-load result source; the reserved encoding behaves as ALU.
    always_comb begin
        sel_data_s = alu_result;
        case (mem_to_reg)
            WB_SRC_PC4: sel_data_s = pc_plus4;
            default:    sel_data_s = alu_result;
        endcase
    end

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .funct3 (ld_f3_r),
        .addr   (ld_addr_r),
        .rdata  (mem_rdata),
        .data   (ext_data_s)
    );

    // Commit FSM with registered write port and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            ld_rd_r     <= 5'd0;
            ld_f3_r     <= 3'd0;
            ld_addr_r   <= 2'd0;
            rf_we       <= 1'b0;
            rf_waddr    <= 5'd0;
            rf_wdata    <= {XLEN{1'b0}};
            load_fault  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            // Pulses default low so every write/fault/timeout lasts one cycle.
            rf_we       <= 1'b0;
            load_fault  <= 1'b0;
            mem_timeout <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (reg_write) begin
                        if (is_load_s) begin
                            if (load_ok_s) begin
                                ld_rd_r   <= rd_s;
                                ld_f3_r   <= funct3_s;
                                ld_addr_r <= alu_result[1:0];
                                cnt_r     <= {CW{1'b0}};
                                state_r   <= ST_WAIT_MEM;
                            end else begin
                                load_fault <= 1'b1;
                            end
                        end else begin
                            rf_we    <= (rd_s != 5'd0);
                            rf_waddr <= rd_s;
                            rf_wdata <= sel_data_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_MEM: begin
                    // A response arriving on the timeout cycle still commits.
                    if (mem_rvalid) begin
                        rf_we    <= (ld_rd_r != 5'd0);
                        rf_waddr <= ld_rd_r;
                        rf_wdata <= ext_data_s;
                        state_r  <= ST_IDLE;
                    end else if (cnt_r == TIMEOUT_C) begin
                        mem_timeout <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
